// File: rtl/id_stage.sv
// Instruction decode: decodes if_inst, reads/forwards operands and registers the micro-op into ID/EX.
// Latency: read enables, addresses and id_stall are combinational; ID/EX outputs are 1 cycle later.
// Backpressure: a load-use hazard raises id_stall for one cycle, so fetch holds while ID/EX takes a bubble.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_inst,
  input  logic              flush,
  output logic              id_stall,
  output logic              re1,
  output logic              re2,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              ex_wreg,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              idex_valid,
  output logic [3:0]        idex_aluop,
  output logic [DATA_W-1:0] idex_opa,
  output logic [DATA_W-1:0] idex_opb,
  output logic              idex_wreg,
  output logic [REG_AW-1:0] idex_waddr,
  output logic              idex_is_load,
  output logic              idex_is_store,
  output logic [DATA_W-1:0] idex_store_data,
  output logic [31:0]       idex_pc,
  output logic              id_illegal,
  output logic [15:0]       stall_cnt
);

  localparam logic [3:0] ALU_NOP   = 4'd0;
  localparam logic [3:0] ALU_AND   = 4'd1;
  localparam logic [3:0] ALU_OR    = 4'd2;
  localparam logic [3:0] ALU_XOR   = 4'd3;
  localparam logic [3:0] ALU_ADD   = 4'd4;
  localparam logic [3:0] ALU_SUB   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_PASSB = 4'd7;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm;

  assign op    = if_inst[31:26];
  assign funct = if_inst[5:0];
  assign rs    = if_inst[25:21];
  assign rt    = if_inst[20:16];
  assign rd    = if_inst[15:11];
  assign imm   = if_inst[15:0];

  logic              dec_ill;
  logic [3:0]        dec_alu;
  logic              use_rs;
  logic              use_rt;
  logic              use_imm;
  logic [DATA_W-1:0] imm_val;
  logic [REG_AW-1:0] dec_dest;
  logic              dec_wreg;
  logic              dec_ld;
  logic              dec_st;

  // Decode opcode/funct into ALU op, source usage, immediate form and destination.
  always_comb begin
    dec_ill  = 1'b0;
    dec_alu  = ALU_NOP;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    use_imm  = 1'b0;
    imm_val  = '0;
    dec_dest = '0;
    dec_wreg = 1'b0;
    dec_ld   = 1'b0;
    dec_st   = 1'b0;
    case (op)
      6'h00: begin
        if (if_inst != 32'h0) begin
          use_rs   = 1'b1;
          use_rt   = 1'b1;
          dec_dest = rd;
          dec_wreg = 1'b1;
          case (funct)
            6'h24:   dec_alu = ALU_AND;
            6'h25:   dec_alu = ALU_OR;
            6'h26:   dec_alu = ALU_XOR;
            6'h21:   dec_alu = ALU_ADD;
            6'h23:   dec_alu = ALU_SUB;
            6'h2A:   dec_alu = ALU_SLT;
            default: begin
              dec_ill  = 1'b1;
              use_rs   = 1'b0;
              use_rt   = 1'b0;
              dec_wreg = 1'b0;
            end
          endcase
        end
      end
      6'h0C, 6'h0D, 6'h0E, 6'h09: begin
        use_rs   = 1'b1;
        use_imm  = 1'b1;
        dec_dest = rt;
        dec_wreg = 1'b1;
        case (op)
          6'h0C:   dec_alu = ALU_AND;
          6'h0D:   dec_alu = ALU_OR;
          6'h0E:   dec_alu = ALU_XOR;
          default: dec_alu = ALU_ADD;
        endcase
        if (op == 6'h09) imm_val = {{(DATA_W-16){imm[15]}}, imm};
        else             imm_val = {{(DATA_W-16){1'b0}}, imm};
      end
      6'h0F: begin
        dec_alu  = ALU_PASSB;
        use_imm  = 1'b1;
        imm_val  = {{(DATA_W-32){1'b0}}, imm, 16'h0};
        dec_dest = rt;
        dec_wreg = 1'b1;
      end
      6'h23: begin
        dec_alu  = ALU_ADD;
        use_rs   = 1'b1;
        use_imm  = 1'b1;
        imm_val  = {{(DATA_W-16){imm[15]}}, imm};
        dec_dest = rt;
        dec_wreg = 1'b1;
        dec_ld   = 1'b1;
      end
      6'h2B: begin
        dec_alu  = ALU_ADD;
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        use_imm  = 1'b1;
        imm_val  = {{(DATA_W-16){imm[15]}}, imm};
        dec_st   = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign re1    = if_valid & use_rs;
  assign re2    = if_valid & use_rt;
  assign raddr1 = rs;
  assign raddr2 = rt;

  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;

  // Per-port operand select: r0, then EX result (never a pending load), then MEM, then regfile.
  always_comb begin
    src1 = rdata1;
    if (rs == '0)                                         src1 = '0;
    else if (ex_wreg && !ex_is_load && ex_waddr == rs)    src1 = ex_wdata;
    else if (mem_wreg && mem_waddr == rs)                 src1 = mem_wdata;
    src2 = rdata2;
    if (rt == '0)                                         src2 = '0;
    else if (ex_wreg && !ex_is_load && ex_waddr == rt)    src2 = ex_wdata;
    else if (mem_wreg && mem_waddr == rt)                 src2 = mem_wdata;
  end

  logic hazard;
  logic take;

  // Load-use: the LW in EX has no data yet, so hold fetch for the one cycle until it reaches MEM.
  always_comb begin
    hazard = ex_is_load && ex_wreg && (ex_waddr != '0) &&
             ((re1 && ex_waddr == rs) || (re2 && ex_waddr == rt));
  end

  assign id_stall = hazard & ~flush;
  assign take     = if_valid & ~flush & ~hazard & ~dec_ill;

  // ID/EX register: real micro-op when accepted, otherwise an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || !take) begin
      idex_valid      <= 1'b0;
      idex_aluop      <= ALU_NOP;
      idex_opa        <= '0;
      idex_opb        <= '0;
      idex_wreg       <= 1'b0;
      idex_waddr      <= '0;
      idex_is_load    <= 1'b0;
      idex_is_store   <= 1'b0;
      idex_store_data <= '0;
      idex_pc         <= '0;
    end else begin
      idex_valid      <= 1'b1;
      idex_aluop      <= dec_alu;
      idex_opa        <= use_rs ? src1 : '0;
      idex_opb        <= use_imm ? imm_val : (use_rt ? src2 : '0);
      idex_wreg       <= dec_wreg && (dec_dest != '0);
      idex_waddr      <= dec_dest;
      idex_is_load    <= dec_ld;
      idex_is_store   <= dec_st;
      idex_store_data <= dec_st ? src2 : '0;
      idex_pc         <= if_pc;
    end
  end

  // Illegal pulse coincides with the bubble it produced; a flush kills it.
  always_ff @(posedge clk) begin
    if (rst) id_illegal <= 1'b0;
    else     id_illegal <= if_valid & ~flush & dec_ill;
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)                                stall_cnt <= '0;
    else if (id_stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
